pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core. Collects hazard and redirect requests from ID, EX and MEM and drives per-stage stall and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also sequences multi-cycle EX operations (divide) with a down-counter, and keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_ctrl.sv | 100 ++++++++++
 tb/tb_pipe_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: turns ID/EX/MEM hazard and redirect requests into
// per-stage stall/flush controls, sequences the multi-cycle divider, counts stall cycles.
module pipe_ctrl #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_load_use_req,
    input  logic             id_branch_taken,
    input  logic             ex_div_start,
    input  logic             mem_exc_req,
    input  logic             perf_clr,
    output logic [5:0]       stall,
    output logic             flush_ifid,
    output logic             flush_all,
    output logic             div_busy,
    output logic             div_done,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int CNT_DW = $clog2(DIV_CYCLES + 1);
    localparam logic [CNT_DW-1:0] DIV_LOAD = CNT_DW'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DIV_RUN,
        DIV_DONE
    } state_t;

    state_t            state, state_n;
    logic [CNT_DW-1:0] div_cnt, div_cnt_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            div_cnt <= '0;
        end else begin
            state   <= state_n;
            div_cnt <= div_cnt_n;
        end
    end

    // An exception overrides everything, including aborting a divide in flight.
    always_comb begin
        state_n   = state;
        div_cnt_n = div_cnt;
        stall     = 6'b000000;
        flush_all = 1'b0;
        div_done  = 1'b0;
        if (mem_exc_req) begin
            flush_all = 1'b1;
            state_n   = IDLE;
            div_cnt_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ex_div_start) begin
                        stall     = 6'b001111;
                        state_n   = DIV_RUN;
                        div_cnt_n = DIV_LOAD;
                    end else if (id_load_use_req) begin
                        stall = 6'b000111;
                    end
                end
                DIV_RUN: begin
                    stall = 6'b001111;
                    if (div_cnt != '0) begin
                        div_cnt_n = div_cnt - CNT_DW'(1);
                    end else begin
                        state_n = DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    div_done = 1'b1;
                    state_n  = IDLE;
                end
                default: begin
                    state_n   = IDLE;
                    div_cnt_n = '0;
                end
            endcase
        end
    end

    // A branch seen while ID is held gets re-evaluated once ID is released.
    assign flush_ifid = id_branch_taken & ~stall[2] & ~flush_all;
    assign div_busy   = (state == DIV_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (perf_clr) begin
            stall_cycles <= '0;
        end else if ((stall != 6'b000000) && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl, built with DIV_CYCLES=4 and CNT_W=4
// so divide timing and counter saturation are both reachable in short runs.
module tb_pipe_ctrl;

    logic       clk;
    logic       rst_n;
    logic       id_load_use_req;
    logic       id_branch_taken;
    logic       ex_div_start;
    logic       mem_exc_req;
    logic       perf_clr;
    logic [5:0] stall;
    logic       flush_ifid;
    logic       flush_all;
    logic       div_busy;
    logic       div_done;
    logic [3:0] stall_cycles;

    int checks = 0;
    int passed = 0;

    pipe_ctrl #(.DIV_CYCLES(4), .CNT_W(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_load_use_req (id_load_use_req),
        .id_branch_taken (id_branch_taken),
        .ex_div_start    (ex_div_start),
        .mem_exc_req     (mem_exc_req),
        .perf_clr        (perf_clr),
        .stall           (stall),
        .flush_ifid      (flush_ifid),
        .flush_all       (flush_all),
        .div_busy        (div_busy),
        .div_done        (div_done),
        .stall_cycles    (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic drive(input logic lu, input logic br, input logic ds, input logic ex, input logic pc);
        id_load_use_req = lu;
        id_branch_taken = br;
        ex_div_start    = ds;
        mem_exc_req     = ex;
        perf_clr        = pc;
        @(negedge clk);
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        checks++; if (stall !== 6'b0 || flush_ifid !== 1'b0 || flush_all !== 1'b0) $display("[TB] FAIL reset_ctrl: stall=%b flush_ifid=%b flush_all=%b, want 0", stall, flush_ifid, flush_all); else passed++;
        checks++; if (div_busy !== 1'b0 || div_done !== 1'b0 || stall_cycles !== 4'd0) $display("[TB] FAIL reset_div: busy=%b done=%b cnt=%0d, want 0", div_busy, div_done, stall_cycles); else passed++;
        next_edge();
        rst_n = 1'b1;
        next_edge();
        drive(0, 0, 0, 0, 0);
        checks++; if (stall !== 6'b0 || flush_ifid !== 1'b0 || flush_all !== 1'b0 || div_busy !== 1'b0 || div_done !== 1'b0 || stall_cycles !== 4'd0) $display("[TB] FAIL idle_after_reset: stall=%b fi=%b fa=%b busy=%b done=%b cnt=%0d, want all 0", stall, flush_ifid, flush_all, div_busy, div_done, stall_cycles); else passed++;
        next_edge();
    endtask

    task automatic test_divide();
        drive(0, 0, 0, 0, 1);
        next_edge();
        for (int i = 0; i < 7; i++) begin
            logic [5:0] exp_stall;
            drive(0, 0, (i == 0), 0, 0);
            exp_stall = (i <= 4) ? 6'b001111 : 6'b000000;
            checks++; if (stall !== exp_stall) $display("[TB] FAIL div_stall c%0d: got %b want %b", i, stall, exp_stall); else passed++;
            checks++; if (div_busy !== (i >= 1 && i <= 4)) $display("[TB] FAIL div_busy c%0d: got %b want %b", i, div_busy, (i >= 1 && i <= 4)); else passed++;
            checks++; if (div_done !== (i == 5)) $display("[TB] FAIL div_done c%0d: got %b want %b", i, div_done, (i == 5)); else passed++;
            next_edge();
        end
        checks++; if (stall_cycles !== 4'd5) $display("[TB] FAIL div_stall_cycles: got %0d want 5", stall_cycles); else passed++;
    endtask

    task automatic test_load_use_branch();
        drive(1, 1, 0, 0, 0);
        checks++; if (stall !== 6'b000111 || flush_ifid !== 1'b0) $display("[TB] FAIL lu_branch: stall=%b fi=%b, want 000111/0", stall, flush_ifid); else passed++;
        next_edge();
        drive(0, 1, 0, 0, 0);
        checks++; if (stall !== 6'b0 || flush_ifid !== 1'b1) $display("[TB] FAIL branch_only: stall=%b fi=%b, want 000000/1", stall, flush_ifid); else passed++;
        next_edge();
        drive(0, 0, 0, 0, 0);
        checks++; if (flush_ifid !== 1'b0 || stall !== 6'b0) $display("[TB] FAIL quiet_after_branch: stall=%b fi=%b, want 0", stall, flush_ifid); else passed++;
        next_edge();
    endtask

    task automatic test_exc_abort();
        for (int i = 0; i < 10; i++) begin
            drive((i == 3), (i == 3), (i == 0), (i == 3), 0);
            if (i == 1 || i == 2) begin
                checks++; if (div_busy !== 1'b1) $display("[TB] FAIL exc_busy_before c%0d: got %b want 1", i, div_busy); else passed++;
            end else if (i == 3) begin
                checks++; if (flush_all !== 1'b1 || stall !== 6'b0 || flush_ifid !== 1'b0) $display("[TB] FAIL exc_cycle: fa=%b stall=%b fi=%b, want 1/000000/0", flush_all, stall, flush_ifid); else passed++;
            end else if (i >= 4) begin
                checks++; if (div_busy !== 1'b0 || div_done !== 1'b0 || stall !== 6'b0 || flush_all !== 1'b0) $display("[TB] FAIL exc_after c%0d: busy=%b done=%b stall=%b fa=%b, want 0", i, div_busy, div_done, stall, flush_all); else passed++;
            end
            next_edge();
        end
    endtask

    task automatic test_saturation();
        drive(0, 0, 0, 0, 1);
        next_edge();
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 0, 0, 0);
            if (i == 14) begin
                checks++; if (stall_cycles !== 4'd14) $display("[TB] FAIL sat_mid: got %0d want 14", stall_cycles); else passed++;
            end
            next_edge();
        end
        drive(0, 0, 0, 0, 0);
        checks++; if (stall_cycles !== 4'd15) $display("[TB] FAIL sat_hold: got %0d want 15", stall_cycles); else passed++;
        next_edge();
        drive(1, 0, 0, 0, 1);
        checks++; if (stall !== 6'b000111) $display("[TB] FAIL clr_stall: got %b want 000111", stall); else passed++;
        next_edge();
        drive(0, 0, 0, 0, 0);
        checks++; if (stall_cycles !== 4'd0) $display("[TB] FAIL clr_priority: got %0d want 0", stall_cycles); else passed++;
        next_edge();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            logic [5:0] exp_stall;
            drive(0, 0, 1, 0, 0);
            exp_stall = (i == 5) ? 6'b000000 : 6'b001111;
            checks++; if (stall !== exp_stall) $display("[TB] FAIL b2b_stall c%0d: got %b want %b", i, stall, exp_stall); else passed++;
            checks++; if (div_done !== (i == 5)) $display("[TB] FAIL b2b_done c%0d: got %b want %b", i, div_done, (i == 5)); else passed++;
            checks++; if (div_busy !== ((i >= 1 && i <= 4) || i == 7)) $display("[TB] FAIL b2b_busy c%0d: got %b want %b", i, div_busy, ((i >= 1 && i <= 4) || i == 7)); else passed++;
            next_edge();
        end
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0, 0);
            next_edge();
        end
    endtask

    task automatic test_async_reset();
        drive(0, 0, 1, 0, 0);
        next_edge();
        drive(0, 0, 0, 0, 0);
        next_edge();
        drive(0, 0, 0, 0, 0);
        checks++; if (div_busy !== 1'b1 || stall !== 6'b001111) $display("[TB] FAIL pre_async: busy=%b stall=%b, want 1/001111", div_busy, stall); else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (div_busy !== 1'b0 || stall !== 6'b0 || stall_cycles !== 4'd0) $display("[TB] FAIL async_reset: busy=%b stall=%b cnt=%0d, want 0/000000/0", div_busy, stall, stall_cycles); else passed++;
        #1;
        rst_n = 1'b1;
        next_edge();
        drive(0, 0, 0, 0, 0);
        checks++; if (div_busy !== 1'b0 || div_done !== 1'b0 || stall !== 6'b0) $display("[TB] FAIL post_async: busy=%b done=%b stall=%b, want 0", div_busy, div_done, stall); else passed++;
        next_edge();
    endtask

    initial begin
        rst_n           = 1'b0;
        id_load_use_req = 1'b0;
        id_branch_taken = 1'b0;
        ex_div_start    = 1'b0;
        mem_exc_req     = 1'b0;
        perf_clr        = 1'b0;
        test_reset();
        test_divide();
        test_load_use_branch();
        test_exc_abort();
        test_saturation();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
